// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch sequencer states
//   NOP_INSTR     : instruction presented to decode while nothing has been fetched yet
//   PC_STEP       : sequential PC increment (one 32-bit word)
//   align_word()  : clears the byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding immunit and the decoder.
// Keeps the fetch PC, issues one word request at a time to instruction memory,
// registers the returned word and hands it to decode with a valid/ready handshake.
// A redirect from execute replaces the fetch PC and discards any instruction that
// is in flight or waiting for decode.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   ImemReqValid/ImemReqReady/ImemAddr   request channel to instruction memory
//   ImemRspValid/ImemRspData             response channel from instruction memory
//   Redirect/RedirectTarget              new fetch target from execute
//   InstrValid/InstrReady                handshake with decode
//   Instr, PC, PCPlus4                   fetched instruction, its address, address + 4
//   ImmInput                             Instr[31:7], wired to immunit
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemReqValid,
    input  logic            ImemReqReady,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemRspValid,
    input  logic [XLEN-1:0] ImemRspData,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectTarget,
    output logic            InstrValid,
    input  logic            InstrReady,
    output logic [XLEN-1:0] Instr,
    output logic [24:0]     ImmInput,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4
);

    fetch_state_t    state_r,       state_s;
    logic [XLEN-1:0] fetch_pc_r,    fetch_pc_s;
    logic [XLEN-1:0] req_pc_r,      req_pc_s;
    logic            kill_r,        kill_s;
    logic [XLEN-1:0] instr_r,       instr_s;
    logic [XLEN-1:0] pc_r,          pc_s;
    logic            instr_valid_r, instr_valid_s;

    // Request is suppressed in the redirect cycle so the stale address never leaves.
    assign ImemReqValid = (state_r == REQ) && !Redirect;
    assign ImemAddr     = fetch_pc_r;
    assign InstrValid   = instr_valid_r;
    assign Instr        = instr_r;
    assign ImmInput     = instr_r[31:7];
    assign PC           = pc_r;
    assign PCPlus4      = pc_r + PC_STEP;

    // Next-state and next-register computation; Redirect outranks every other event.
    always_comb begin
        state_s       = state_r;
        fetch_pc_s    = fetch_pc_r;
        req_pc_s      = req_pc_r;
        kill_s        = kill_r;
        instr_s       = instr_r;
        pc_s          = pc_r;
        instr_valid_s = instr_valid_r;

        case (state_r)
            IDLE: begin
                state_s = REQ;
            end

            REQ: begin
                if (Redirect) begin
                    fetch_pc_s = align_word(RedirectTarget);
                end else if (ImemReqReady) begin
                    req_pc_s   = fetch_pc_r;
                    fetch_pc_s = fetch_pc_r + PC_STEP;
                    state_s    = WAIT;
                end else begin
                    state_s = REQ;
                end
            end

            WAIT: begin
                if (Redirect) begin
                    fetch_pc_s = align_word(RedirectTarget);
                    if (ImemRspValid) begin
                        // Stale response consumed right now, nothing left to kill.
                        kill_s  = 1'b0;
                        state_s = REQ;
                    end else begin
                        // Response still in flight: remember to drop it.
                        kill_s = 1'b1;
                    end
                end else if (ImemRspValid) begin
                    if (kill_r) begin
                        kill_s  = 1'b0;
                        state_s = REQ;
                    end else begin
                        instr_s       = ImemRspData;
                        pc_s          = req_pc_r;
                        instr_valid_s = 1'b1;
                        state_s       = HOLD;
                    end
                end else begin
                    state_s = WAIT;
                end
            end

            HOLD: begin
                if (Redirect) begin
                    fetch_pc_s    = align_word(RedirectTarget);
                    instr_valid_s = 1'b0;
                    state_s       = REQ;
                end else if (InstrReady) begin
                    instr_valid_s = 1'b0;
                    state_s       = REQ;
                end else begin
                    state_s = HOLD;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            fetch_pc_r    <= RESET_PC;
            req_pc_r      <= RESET_PC;
            kill_r        <= 1'b0;
            instr_r       <= NOP_INSTR;
            pc_r          <= RESET_PC;
            instr_valid_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            fetch_pc_r    <= fetch_pc_s;
            req_pc_r      <= req_pc_s;
            kill_r        <= kill_s;
            instr_r       <= instr_s;
            pc_r          <= pc_s;
            instr_valid_r <= instr_valid_s;
        end
    end

endmodule
